// File: rtl/img2col_pkg.sv
// Shared types and helpers for the img2col window processing unit.
package img2col_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam int unsigned PIX_W = 16;
    typedef logic [PIX_W-1:0] pixel_t;

    // Flat window index of pixel (column c, row r); column 0 is the oldest.
    function automatic int unsigned win_idx(input int unsigned c, input int unsigned r,
                                            input int unsigned k);
        return c * k + r;
    endfunction

    function automatic bit cfg_ok(input int unsigned k, input int unsigned stride,
                                  input int unsigned lanes);
        return (stride >= 1) && (stride < k) && (lanes >= 1);
    endfunction

endpackage

// File: rtl/img2col_window_pu_new_buf.sv
// Multi-port new-column buffer with a written-entry bitmap and synchronous bitmap clear.
module pu_new_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NEW_N  = 5,
    parameter int unsigned LANES  = 2,
    parameter int unsigned AW     = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic [LANES-1:0]        i_wr_en,
    input  logic [LANES*AW-1:0]     i_wr_addr,
    input  logic [LANES*DATA_W-1:0] i_wr_data,
    output logic [NEW_N*DATA_W-1:0] o_data,
    output logic                    o_full
);

    logic [NEW_N-1:0]        r_map;
    logic [NEW_N*DATA_W-1:0] r_data;
    logic [NEW_N-1:0]        w_set;

    always_comb begin
        w_set = '0;
        for (int unsigned e = 0; e < NEW_N; e++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (i_wr_en[l] && (i_wr_addr[l*AW +: AW] == AW'(e)))
                    w_set[e] = 1'b1;
            end
        end
    end

    // Ascending lane loop: the last non-blocking write, i.e. the highest lane, wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_map  <= '0;
            r_data <= '0;
        end else begin
            r_map <= i_clr ? '0 : (r_map | w_set);
            for (int unsigned e = 0; e < NEW_N; e++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (i_wr_en[l] && (i_wr_addr[l*AW +: AW] == AW'(e)))
                        r_data[e*DATA_W +: DATA_W] <= i_wr_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Full including this cycle's writes, so the completing write can trigger EMIT directly.
    assign o_full = &(r_map | w_set);
    assign o_data = r_data;

endmodule

// File: rtl/img2col_window_pu.sv
// img2col processing unit: builds successive KxK windows from retained and newly written columns.
module img2col_window_pu
    import img2col_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned K      = 5,
    parameter  int unsigned STRIDE = 1,
    parameter  int unsigned LANES  = 2,
    localparam int unsigned NEW_N  = STRIDE * K,
    localparam int unsigned OLD_N  = (K - STRIDE) * K,
    localparam int unsigned AW     = (NEW_N > 1) ? $clog2(NEW_N) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [7:0]              i_n_windows,
    input  logic                    i_first_from_nb,
    input  logic [LANES-1:0]        i_wr_en,
    input  logic [LANES*AW-1:0]     i_wr_addr,
    input  logic [LANES*DATA_W-1:0] i_wr_data,
    input  logic                    i_nb_in_valid,
    input  logic [OLD_N*DATA_W-1:0] i_nb_in,
    output logic                    o_nb_in_ready,
    output logic                    o_nb_out_valid,
    output logic [OLD_N*DATA_W-1:0] o_nb_out,
    output logic                    o_win_valid,
    input  logic                    i_win_ready,
    output logic [K*K*DATA_W-1:0]   o_win,
    output logic                    o_busy,
    output logic                    o_done
);

    if (!cfg_ok(K, STRIDE, LANES)) begin : g_bad_cfg
        $error("img2col_window_pu: need 1 <= STRIDE < K and LANES >= 1");
    end

    state_t                  r_state;
    logic [7:0]              r_n_win;
    logic [7:0]              r_win_cnt;
    logic                    r_old_ok;
    logic [OLD_N*DATA_W-1:0] r_old;
    logic [OLD_N*DATA_W-1:0] r_nb_out;
    logic                    r_nb_out_valid;
    logic                    r_done;

    logic [LANES-1:0]        w_wr_en;
    logic                    w_buf_clr;
    logic                    w_accept;
    logic                    w_nb_hs;
    logic                    w_full;
    logic [NEW_N*DATA_W-1:0] w_new;
    logic [OLD_N*DATA_W-1:0] w_slide;

    assign w_wr_en   = (r_state == ST_LOAD) ? i_wr_en : '0;
    assign w_accept  = (r_state == ST_EMIT) && i_win_ready;
    assign w_buf_clr = ((r_state == ST_IDLE) && i_start) || w_accept;
    assign w_nb_hs   = o_nb_in_ready && i_nb_in_valid;

    pu_new_buf #(
        .DATA_W (DATA_W),
        .NEW_N  (NEW_N),
        .LANES  (LANES),
        .AW     (AW)
    ) u_new_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_buf_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .o_data    (w_new),
        .o_full    (w_full)
    );

    always_comb begin
        o_win = '0;
        for (int unsigned c = 0; c < K; c++) begin
            for (int unsigned r = 0; r < K; r++) begin
                if (c < K - STRIDE)
                    o_win[win_idx(c, r, K)*DATA_W +: DATA_W] = r_old[win_idx(c, r, K)*DATA_W +: DATA_W];
                else
                    o_win[win_idx(c, r, K)*DATA_W +: DATA_W] =
                        w_new[win_idx(c - (K - STRIDE), r, K)*DATA_W +: DATA_W];
            end
        end
    end

    assign w_slide = o_win[K*K*DATA_W-1 : STRIDE*K*DATA_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_n_win        <= '0;
            r_win_cnt      <= '0;
            r_old_ok       <= 1'b0;
            r_old          <= '0;
            r_nb_out       <= '0;
            r_nb_out_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_nb_out_valid <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_n_win   <= i_n_windows;
                        r_win_cnt <= '0;
                        if (i_n_windows == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_old_ok <= !i_first_from_nb;
                            if (!i_first_from_nb)
                                r_old <= '0;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_nb_hs) begin
                        r_old    <= i_nb_in;
                        r_old_ok <= 1'b1;
                    end
                    if (w_full && (r_old_ok || w_nb_hs))
                        r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (i_win_ready) begin
                        r_win_cnt <= r_win_cnt + 8'd1;
                        r_old     <= w_slide;
                        if (r_win_cnt + 8'd1 == r_n_win) begin
                            r_nb_out       <= w_slide;
                            r_nb_out_valid <= 1'b1;
                            r_done         <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_nb_in_ready  = (r_state == ST_LOAD) && !r_old_ok;
    assign o_win_valid    = (r_state == ST_EMIT);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_nb_out_valid = r_nb_out_valid;
    assign o_nb_out       = r_nb_out;
    assign o_done         = r_done;

endmodule

// File: tb/tb_img2col_window_pu.sv
// Self-checking bench for img2col_window_pu against a pixel-array reference model.
module tb_img2col_window_pu;
    import img2col_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned K      = 5;
    localparam int unsigned STRIDE = 1;
    localparam int unsigned LANES  = 2;
    localparam int unsigned NEW_N  = STRIDE * K;
    localparam int unsigned OLD_N  = (K - STRIDE) * K;
    localparam int unsigned AW     = 3;
    localparam int unsigned WIN_N  = K * K;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [7:0]              n_windows = '0;
    logic                    first_from_nb = 1'b0;
    logic [LANES-1:0]        wr_en = '0;
    logic [LANES*AW-1:0]     wr_addr = '0;
    logic [LANES*DATA_W-1:0] wr_data = '0;
    logic                    nb_in_valid = 1'b0;
    logic [OLD_N*DATA_W-1:0] nb_in = '0;
    logic                    nb_in_ready;
    logic                    nb_out_valid;
    logic [OLD_N*DATA_W-1:0] nb_out;
    logic                    win_valid;
    logic                    win_ready = 1'b0;
    logic [WIN_N*DATA_W-1:0] win;
    logic                    busy;
    logic                    done;

    int errors = 0;
    int checks = 0;

    pixel_t m_old [OLD_N];
    pixel_t m_new [NEW_N];
    bit     m_filled [NEW_N];

    always #5 clk = ~clk;

    img2col_window_pu #(
        .DATA_W (DATA_W),
        .K      (K),
        .STRIDE (STRIDE),
        .LANES  (LANES)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_n_windows    (n_windows),
        .i_first_from_nb(first_from_nb),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_nb_in_valid  (nb_in_valid),
        .i_nb_in        (nb_in),
        .o_nb_in_ready  (nb_in_ready),
        .o_nb_out_valid (nb_out_valid),
        .o_nb_out       (nb_out),
        .o_win_valid    (win_valid),
        .i_win_ready    (win_ready),
        .o_win          (win),
        .o_busy         (busy),
        .o_done         (done)
    );

    // ---------------- reference model ----------------
    function automatic logic [WIN_N*DATA_W-1:0] exp_win();
        logic [WIN_N*DATA_W-1:0] v;
        for (int i = 0; i < WIN_N; i++)
            v[i*DATA_W +: DATA_W] = (i < OLD_N) ? m_old[i] : m_new[i-OLD_N];
        return v;
    endfunction

    function automatic logic [OLD_N*DATA_W-1:0] exp_tail();
        logic [WIN_N*DATA_W-1:0] v;
        v = exp_win();
        return v[WIN_N*DATA_W-1 : STRIDE*K*DATA_W];
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < NEW_N; i++)
            if (!m_filled[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic pixel_t rnd_pix();
        return pixel_t'($urandom);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < OLD_N; i++) m_old[i] = '0;
        for (int i = 0; i < NEW_N; i++) begin
            m_new[i] = '0;
            m_filled[i] = 1'b0;
        end
    endtask

    task automatic model_write(input bit e, input int unsigned a, input pixel_t d);
        if (e && a < NEW_N) begin
            m_new[a]    = d;
            m_filled[a] = 1'b1;
        end
    endtask

    task automatic model_accept();
        pixel_t w [WIN_N];
        for (int i = 0; i < WIN_N; i++) w[i] = (i < OLD_N) ? m_old[i] : m_new[i-OLD_N];
        for (int j = 0; j < OLD_N; j++) m_old[j] = w[j + STRIDE*K];
        for (int i = 0; i < NEW_N; i++) m_filled[i] = 1'b0;
    endtask

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic start_row(input int unsigned n, input bit fnb);
        n_windows     = 8'(n);
        first_from_nb = fnb;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n != 0) begin
            for (int i = 0; i < NEW_N; i++) m_filled[i] = 1'b0;
            if (!fnb)
                for (int i = 0; i < OLD_N; i++) m_old[i] = '0;
        end
    endtask

    task automatic wcycle(input bit e0, input int unsigned a0, input pixel_t d0,
                          input bit e1, input int unsigned a1, input pixel_t d1,
                          input bit apply);
        wr_en   = {e1, e0};
        wr_addr = {3'(a1), 3'(a0)};
        wr_data = {d1, d0};
        if (apply) begin
            model_write(e0, a0, d0);
            model_write(e1, a1, d1);
        end
        @(negedge clk);
        wr_en = '0;
    endtask

    task automatic accept();
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        model_accept();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_zero_pad();
        logic [OLD_N*DATA_W-1:0] t;
        start_row(1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zp_busy: got %b exp 1", busy); end
        wcycle(1, 0, 16'd1, 1, 1, 16'd2, 1);
        wcycle(1, 2, 16'd3, 1, 3, 16'd4, 1);
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL zp_early_valid: got %b exp 0", win_valid); end
        wcycle(1, 4, 16'd5, 0, 0, 16'd0, 1);
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL zp_valid: got %b exp 1", win_valid); end
        checks++; if (win !== exp_win()) begin errors++; $display("FAIL zp_win: got %h exp %h", win, exp_win()); end
        checks++; if (win[20*DATA_W +: DATA_W] !== 16'd1) begin errors++; $display("FAIL zp_px20: got %h exp 0001", win[20*DATA_W +: DATA_W]); end
        t = exp_tail();
        accept();
        checks++; if ({nb_out_valid, done, busy} !== 3'b110) begin errors++; $display("FAIL zp_end_flags: got %b exp 110", {nb_out_valid, done, busy}); end
        checks++; if (nb_out !== t) begin errors++; $display("FAIL zp_nb_out: got %h exp %h", nb_out, t); end
        @(negedge clk);
        checks++; if ({nb_out_valid, done} !== 2'b00) begin errors++; $display("FAIL zp_pulse_len: got %b exp 00", {nb_out_valid, done}); end
    endtask

    task automatic test_reset();
        start_row(2, 1'b0);
        wcycle(1, 0, rnd_pix(), 1, 1, rnd_pix(), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({nb_in_ready, nb_out_valid, win_valid, busy, done} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got %b exp 00000", {nb_in_ready, nb_out_valid, win_valid, busy, done}); end
        checks++; if (nb_out !== '0) begin errors++; $display("FAIL rst_nb_out: got %h exp 0", nb_out); end
        checks++; if (win !== '0) begin errors++; $display("FAIL rst_win: got %h exp 0", win); end
        rst = 1'b0;
        model_reset();
        wcycle(1, 0, rnd_pix(), 1, 1, rnd_pix(), 0);
        wcycle(1, 2, rnd_pix(), 1, 3, rnd_pix(), 0);
        wcycle(1, 4, rnd_pix(), 0, 0, 16'd0, 0);
        @(negedge clk);
        checks++; if ({busy, win_valid} !== 2'b00) begin errors++; $display("FAIL rst_idle_writes: got %b exp 00", {busy, win_valid}); end
        checks++; if (win !== '0) begin errors++; $display("FAIL rst_buf_untouched: got %h exp 0", win); end
    endtask

    task automatic test_neighbour();
        logic [OLD_N*DATA_W-1:0] t;
        start_row(1, 1'b1);
        checks++; if (nb_in_ready !== 1'b1) begin errors++; $display("FAIL nb_ready_up: got %b exp 1", nb_in_ready); end
        wcycle(1, 0, rnd_pix(), 1, 1, rnd_pix(), 1);
        wcycle(1, 2, rnd_pix(), 1, 3, rnd_pix(), 1);
        wcycle(1, 4, rnd_pix(), 0, 0, 16'd0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({win_valid, nb_in_ready} !== 2'b01) begin
                errors++; $display("FAIL nb_wait%0d: got %b exp 01", i, {win_valid, nb_in_ready}); end
            if (i < 3) @(negedge clk);
        end
        for (int i = 0; i < OLD_N; i++) begin
            nb_in[i*DATA_W +: DATA_W] = 16'(100 + i);
            m_old[i] = 16'(100 + i);
        end
        nb_in_valid = 1'b1;
        @(negedge clk);
        nb_in_valid = 1'b0;
        checks++; if ({win_valid, nb_in_ready} !== 2'b10) begin errors++; $display("FAIL nb_after_hs: got %b exp 10", {win_valid, nb_in_ready}); end
        checks++; if (win !== exp_win()) begin errors++; $display("FAIL nb_win: got %h exp %h", win, exp_win()); end
        checks++; if (win[19*DATA_W +: DATA_W] !== 16'd119) begin errors++; $display("FAIL nb_px19: got %h exp 0077", win[19*DATA_W +: DATA_W]); end
        t = exp_tail();
        accept();
        checks++; if (nb_out !== t || done !== 1'b1) begin errors++; $display("FAIL nb_out: got %h/%b exp %h/1", nb_out, done, t); end
    endtask

    task automatic test_slide();
        int unsigned b;
        start_row(3, 1'b0);
        for (int w = 0; w < 3; w++) begin
            b = 5 * w;
            wcycle(1, 0, 16'(b+1), 1, 1, 16'(b+2), 1);
            wcycle(1, 2, 16'(b+3), 1, 3, 16'(b+4), 1);
            wcycle(1, 4, 16'(b+5), 0, 0, 16'd0, 1);
            checks++; if (win_valid !== 1'b1 || win !== exp_win()) begin
                errors++; $display("FAIL sl_win%0d: got %b/%h exp 1/%h", w, win_valid, win, exp_win()); end
            if (w == 1) begin
                checks++; if (win[19*DATA_W +: DATA_W] !== 16'd5 || win[20*DATA_W +: DATA_W] !== 16'd6) begin
                    errors++; $display("FAIL sl_w2_px: got %h,%h exp 0005,0006", win[19*DATA_W +: DATA_W], win[20*DATA_W +: DATA_W]); end
            end
            accept();
            if (w < 2) begin
                checks++; if ({done, win_valid, busy} !== 3'b001) begin
                    errors++; $display("FAIL sl_mid%0d: got %b exp 001", w, {done, win_valid, busy}); end
            end else begin
                checks++; if (done !== 1'b1 || nb_out !== {m_old[19], m_old[18], m_old[17], m_old[16], m_old[15],
                                                              m_old[14], m_old[13], m_old[12], m_old[11], m_old[10],
                                                              m_old[9], m_old[8], m_old[7], m_old[6], m_old[5],
                                                              m_old[4], m_old[3], m_old[2], m_old[1], m_old[0]}) begin
                    errors++; $display("FAIL sl_nb_out: got %h done=%b", nb_out, done); end
                checks++; if (nb_out[19*DATA_W +: DATA_W] !== 16'd15) begin
                    errors++; $display("FAIL sl_nb_last: got %h exp 000f", nb_out[19*DATA_W +: DATA_W]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIN_N*DATA_W-1:0] saved;
        logic [OLD_N*DATA_W-1:0] t;
        start_row(1, 1'b0);
        wcycle(1, 2, 16'hAA, 1, 2, 16'hBB, 1);
        wcycle(1, 7, 16'h77, 1, 0, rnd_pix(), 1);
        wcycle(1, 1, rnd_pix(), 1, 3, rnd_pix(), 1);
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_addr7: got %b exp 0", win_valid); end
        wcycle(1, 4, rnd_pix(), 0, 0, 16'd0, 1);
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b exp 1", win_valid); end
        checks++; if (win[22*DATA_W +: DATA_W] !== 16'hBB) begin errors++; $display("FAIL bp_collision: got %h exp 00bb", win[22*DATA_W +: DATA_W]); end
        checks++; if (win !== exp_win()) begin errors++; $display("FAIL bp_win: got %h exp %h", win, exp_win()); end
        saved = win;
        for (int i = 0; i < 5; i++) begin
            wcycle(1, $urandom_range(0, 4), rnd_pix(), 1, $urandom_range(0, 4), rnd_pix(), 0);
            checks++; if (win_valid !== 1'b1 || win !== saved) begin
                errors++; $display("FAIL bp_hold%0d: got %b/%h exp 1/%h", i, win_valid, win, saved); end
        end
        t = exp_tail();
        accept();
        checks++; if (nb_out !== t || done !== 1'b1) begin errors++; $display("FAIL bp_nb_out: got %h/%b exp %h/1", nb_out, done, t); end
    endtask

    task automatic test_zero_windows();
        logic [OLD_N*DATA_W-1:0] prev;
        @(negedge clk);
        prev = nb_out;
        start_row(0, 1'b0);
        checks++; if ({done, win_valid, busy, nb_out_valid} !== 4'b1000) begin
            errors++; $display("FAIL zw_flags: got %b exp 1000", {done, win_valid, busy, nb_out_valid}); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || nb_out !== prev) begin errors++; $display("FAIL zw_after: got done=%b nb_out=%h exp 0/%h", done, nb_out, prev); end
    endtask

    task automatic test_random_rows();
        int unsigned n, cyc, a0, a1;
        bit fnb, ok, e0, e1, nbv;
        pixel_t d0, d1;
        logic [OLD_N*DATA_W-1:0] t;
        for (int row = 0; row < 6; row++) begin
            n   = $urandom_range(1, 4);
            fnb = 1'($urandom);
            start_row(n, fnb);
            ok = !fnb;
            for (int w = 0; w < int'(n); w++) begin
                cyc = 0;
                while (!(model_full() && ok) && cyc < 100) begin
                    checks++; if (nb_in_ready !== !ok) begin
                        errors++; $display("FAIL rnd_nb_ready r%0d w%0d: got %b exp %b", row, w, nb_in_ready, !ok); end
                    e0 = ($urandom % 4) != 0; e1 = ($urandom % 4) != 0;
                    a0 = $urandom_range(0, 7); a1 = $urandom_range(0, 7);
                    d0 = rnd_pix(); d1 = rnd_pix();
                    nbv = ($urandom % 3) == 0;
                    for (int i = 0; i < OLD_N; i++) nb_in[i*DATA_W +: DATA_W] = rnd_pix();
                    nb_in_valid = nbv;
                    start = ($urandom % 8) == 0;
                    n_windows = 8'($urandom);
                    if (nbv && !ok) begin
                        for (int i = 0; i < OLD_N; i++) m_old[i] = nb_in[i*DATA_W +: DATA_W];
                        ok = 1'b1;
                    end
                    wcycle(e0, a0, d0, e1, a1, d1, 1);
                    nb_in_valid = 1'b0;
                    start = 1'b0;
                    cyc++;
                    checks++; if (win_valid !== (model_full() && ok)) begin
                        errors++; $display("FAIL rnd_valid r%0d w%0d c%0d: got %b exp %b", row, w, cyc, win_valid, model_full() && ok); end
                end
                checks++; if (win !== exp_win()) begin errors++; $display("FAIL rnd_win r%0d w%0d: got %h exp %h", row, w, win, exp_win()); end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL rnd_hold r%0d w%0d: got %b exp 1", row, w, win_valid); end
                end
                t = exp_tail();
                accept();
                if (w == int'(n) - 1) begin
                    checks++; if (done !== 1'b1 || nb_out_valid !== 1'b1 || nb_out !== t) begin
                        errors++; $display("FAIL rnd_end r%0d: got %b%b/%h exp 11/%h", row, done, nb_out_valid, nb_out, t); end
                end else begin
                    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
                        errors++; $display("FAIL rnd_mid r%0d w%0d: got done=%b busy=%b exp 0/1", row, w, done, busy); end
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_zero_pad();
        test_reset();
        test_neighbour();
        test_slide();
        test_backpressure();
        test_zero_windows();
        test_random_rows();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
